slave_regfile: RTL and testbench

- Slave-side endpoint downstream of the 3-master/2-slave interconnect. One instance per slave.
- Accepts valid/addr/value transfers with a programmable ready delay and writes each accepted value into an 8-entry register file.
- Provides a registered read-back port and a saturating write counter, used by the bench and by later stages.

---
 rtl/inter_pkg.sv | 17 +
 rtl/slave_rf_mem.sv | 42 ++++
 rtl/slave_regfile.sv | 116 +++++++++++
 tb/tb_slave_regfile.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/inter_pkg.sv
// Shared definitions for the interconnect and its slave endpoints.
//   slv_state_e : slave handshake FSM states
//   ADDR_W      : register-file address width shared with the interconnect
//   DATA_W      : transfer data width shared with the interconnect
package inter_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } slv_state_e;

endpackage

// File: rtl/slave_rf_mem.sv
// Register array for the slave endpoint: 2**ADDR_W entries of DATA_W bits,
// one write port and one registered read port.
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   we         : write enable; waddr/wdata written at the rising edge
//   re         : read enable; rdata <= mem[raddr] at the rising edge, else held
//   rdata      : registered read data
// A read and a write to the same entry at the same edge return the old value.
module slave_rf_mem #(
    parameter int ADDR_W = inter_pkg::ADDR_W,
    parameter int DATA_W = inter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/slave_regfile.sv
// Slave endpoint behind the interconnect. Accepts valid/addr/value transfers
// with a programmable ready delay and stores each accepted value in a small
// register file with a registered read-back port.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid      : transfer request, held until handshake
//   addr_in    : target entry
//   value_in   : write data
//   wait_cfg   : cycles from seeing valid to raising ready (sampled in IDLE)
//   ready      : registered, slave can accept
//   wr_pulse   : registered, high for one cycle after each accepted write
//   rd_en      : read request
//   rd_addr    : read address
//   rd_data    : registered read data, one cycle after rd_en
//   wr_count   : accepted-write counter, saturating at all-ones
module slave_regfile #(
    parameter int ADDR_W = inter_pkg::ADDR_W,
    parameter int DATA_W = inter_pkg::DATA_W,
    parameter int DLY_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] value_in,
    input  logic [DLY_W-1:0]  wait_cfg,
    output logic              ready,
    output logic              wr_pulse,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  wr_count
);

    import inter_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slv_state_e       state;
    logic [DLY_W-1:0] cnt;
    logic             handshake;

    // ready is only ever high in READY, so this is the accepting edge
    assign handshake = valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            wr_pulse <= 1'b0;
            wr_count <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (wait_cfg == '0) begin
                            state <= READY;
                            ready <= 1'b1;
                        end else begin
                            // wait_cfg is latched here; later changes are ignored
                            cnt   <= wait_cfg - DLY_W'(1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!valid) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                READY: begin
                    ready <= 1'b0;
                    if (handshake) begin
                        wr_pulse <= 1'b1;
                        state    <= DONE;
                        if (wr_count != CNT_MAX) begin
                            wr_count <= wr_count + CNT_W'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    // one guaranteed ready-low cycle between transfers
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    slave_rf_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (handshake),
        .waddr (addr_in),
        .wdata (value_in),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_slave_regfile.sv
// Randomized bench for slave_regfile. A transaction-level model (array of
// entries plus an accepted-write tally) predicts ready timing, wr_pulse,
// read data and both an 8-bit and a 2-bit saturating write counter.
module tb_slave_regfile;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [2:0] addr_in;
    logic [2:0] value_in;
    logic [2:0] wait_cfg;
    logic       ready;
    logic       wr_pulse;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic [2:0] rd_data;
    logic [7:0] wr_count;

    logic       ready_s;
    logic       wr_pulse_s;
    logic [2:0] rd_data_s;
    logic [1:0] wr_count_s;

    int total = 0;
    int bad   = 0;

    logic [2:0] mem_m [8];
    int         nwr;

    slave_regfile #(.ADDR_W(3), .DATA_W(3), .DLY_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .addr_in(addr_in),
        .value_in(value_in), .wait_cfg(wait_cfg), .ready(ready),
        .wr_pulse(wr_pulse), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_count(wr_count)
    );

    slave_regfile #(.ADDR_W(3), .DATA_W(3), .DLY_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid(valid), .addr_in(addr_in),
        .value_in(value_in), .wait_cfg(wait_cfg), .ready(ready_s),
        .wr_pulse(wr_pulse_s), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .wr_count(wr_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int lim);
        return (n > lim) ? lim : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transfer: ready expected exactly d+1 edges after valid rises.
    task automatic do_write(input logic [2:0] a, input logic [2:0] v,
                            input logic [2:0] d, input bit rdw);
        logic [2:0] old;
        valid = 1'b1; addr_in = a; value_in = v; wait_cfg = d;
        for (int k = 0; k <= int'(d); k++) begin
            step();
            chk("ready_lat", 32'(ready), 32'(k == int'(d)));
            chk("pulse_early", 32'(wr_pulse), 0);
            if (k == 0) wait_cfg = 3'($urandom_range(0, 7));
        end
        old = mem_m[a];
        if (rdw) begin
            rd_en = 1'b1; rd_addr = a;
        end
        step();
        nwr++;
        mem_m[a] = v;
        chk("ready_after_hs", 32'(ready), 0);
        chk("wr_pulse", 32'(wr_pulse), 1);
        chk("wr_count", 32'(wr_count), 32'(sat(nwr, 255)));
        chk("wr_count_sat", 32'(wr_count_s), 32'(sat(nwr, 3)));
        if (rdw) chk("rdw_old", 32'(rd_data), 32'(old));
        rd_en = 1'b0;
        valid = 1'b0;
        step();
        chk("done_ready", 32'(ready), 0);
        chk("done_pulse", 32'(wr_pulse), 0);
    endtask

    // Valid drops after j edges while the FSM is still waiting.
    task automatic do_abort(input logic [2:0] d, input int j);
        valid = 1'b1; addr_in = 3'($urandom); value_in = 3'($urandom); wait_cfg = d;
        for (int k = 0; k < j; k++) begin
            step();
            chk("abort_ready", 32'(ready), 0);
        end
        valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("abort_ready2", 32'(ready), 0);
            chk("abort_pulse", 32'(wr_pulse), 0);
            chk("abort_count", 32'(wr_count), 32'(sat(nwr, 255)));
        end
    endtask

    task automatic do_read(input logic [2:0] a);
        logic [2:0] exp;
        exp = mem_m[a];
        rd_en = 1'b1; rd_addr = a;
        step();
        chk("rd_data", 32'(rd_data), 32'(exp));
        rd_en = 1'b0; rd_addr = 3'($urandom);
        step();
        chk("rd_hold", 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; addr_in = '0; value_in = '0; wait_cfg = '0;
        rd_en = 1'b0; rd_addr = '0;
        nwr = 0;
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        step();
        step();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_pulse", 32'(wr_pulse), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_count", 32'(wr_count), 0);
        rst_n = 1'b1;
        step();

        // zero-delay write then read back
        do_write(3'd5, 3'd6, 3'd0, 1'b0);
        do_read(3'd5);
        // delayed write
        do_write(3'd2, 3'd3, 3'd3, 1'b0);
        // abort during WAIT
        do_abort(3'd4, 2);
        // read-during-write returns old contents
        do_write(3'd7, 3'd1, 3'd1, 1'b0);
        do_write(3'd7, 3'd4, 3'd0, 1'b1);
        do_read(3'd7);
        // back-to-back writes, saturating the narrow counter
        for (int i = 0; i < 5; i++) begin
            do_write(3'($urandom), 3'($urandom), 3'($urandom_range(0, 2)), 1'b0);
        end

        // randomized mix
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 6) begin
                do_write(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
            end else if (op < 8) begin
                do_read(3'($urandom));
            end else begin
                logic [2:0] d;
                d = 3'($urandom_range(2, 7));
                do_abort(d, $urandom_range(1, int'(d)));
            end
        end

        // reset in the middle of a waiting transfer
        do_write(3'd3, 3'd5, 3'd0, 1'b0);
        do_read(3'd3);
        valid = 1'b1; addr_in = 3'd1; value_in = 3'd7; wait_cfg = 3'd5;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_count", 32'(wr_count), 0);
        chk("midrst_count_sat", 32'(wr_count_s), 0);
        chk("midrst_rd_data", 32'(rd_data), 0);
        valid = 1'b0;
        step();
        rst_n = 1'b1;
        nwr = 0;
        for (int i = 0; i < 8; i++) mem_m[i] = '0;
        step();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_addr = 3'(i);
            step();
            chk("post_rst_entry", 32'(rd_data), 0);
        end
        rd_en = 1'b0;

        // operation resumes normally after reset
        for (int i = 0; i < 6; i++) begin
            do_write(3'($urandom), 3'($urandom), 3'($urandom), 1'b0);
            do_read(3'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
